// File: rtl/fetch_decode_queue_if.sv
// fetch_decode_queue_if: Fetch-side push handshake plus the decoded head entry seen by execute.
interface fetch_decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32
);
  localparam int CW = $clog2(DEPTH + 1);
  logic inValid;
  logic [XLEN-1:0] inInstr;
  logic [XLEN-1:0] inPC;
  logic inReady;
  logic flush;
  logic outReady;
  logic outValid;
  logic [XLEN-1:0] outPC;
  logic [6:0] outOpcode;
  logic [4:0] outRd;
  logic [4:0] outRs1;
  logic [4:0] outRs2;
  logic [2:0] outFunct3;
  logic [6:0] outFunct7;
  logic [2:0] outFormat;
  logic [XLEN-1:0] outImm;
  logic outIllegal;
  logic [CW-1:0] count;
  modport master (
    output inValid, inInstr, inPC, flush, outReady,
    input inReady, outValid, outPC, outOpcode, outRd, outRs1, outRs2,
    input outFunct3, outFunct7, outFormat, outImm, outIllegal, count
  );
  modport slave (
    input inValid, inInstr, inPC, flush, outReady,
    output inReady, outValid, outPC, outOpcode, outRd, outRs1, outRs2,
    output outFunct3, outFunct7, outFormat, outImm, outIllegal, count
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular buffer of {PC, instr} whose head entry is presented field-decoded.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32
) (
  input logic clock,
  input logic reset,
  fetch_decode_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] pcMem [DEPTH];
  logic [XLEN-1:0] instrMem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] occ;
  logic push;
  logic pop;
  logic [XLEN-1:0] instr;
  logic [2:0] fmt;
  logic [XLEN-1:0] imm;
  // readiness comes from the registered count only, so a full queue never accepts on a pop cycle
  assign q.inReady = occ != CW'(DEPTH);
  assign q.outValid = occ != '0;
  assign q.count = occ;
  assign push = q.inValid && q.inReady && !q.flush;
  assign pop = q.outValid && q.outReady && !q.flush;
  always_ff @(posedge clock or posedge reset) begin
    if (reset || q.flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occ <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop) rdPtr <= rdPtr + AW'(1);
      occ <= occ + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      pcMem[wrPtr] <= q.inPC;
      instrMem[wrPtr] <= q.inInstr;
    end
  end
  // an empty queue decodes an all-zero word, which lands in the unknown branch with imm 0
  assign instr = q.outValid ? instrMem[rdPtr] : '0;
  always_comb begin
    fmt = 3'd7;
    imm = '0;
    case (instr[6:0])
      7'b0110011: fmt = 3'd0;
      7'b0010011, 7'b0000011, 7'b1100111: begin
        fmt = 3'd1;
        imm = XLEN'($signed(instr[31:20]));
      end
      7'b0100011: begin
        fmt = 3'd2;
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      7'b1100011: begin
        fmt = 3'd3;
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        fmt = 3'd4;
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        fmt = 3'd5;
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      default: fmt = 3'd7;
    endcase
  end
  assign q.outPC = q.outValid ? pcMem[rdPtr] : '0;
  assign q.outOpcode = instr[6:0];
  assign q.outRd = instr[11:7];
  assign q.outRs1 = instr[19:15];
  assign q.outRs2 = instr[24:20];
  assign q.outFunct3 = instr[14:12];
  assign q.outFunct7 = instr[31:25];
  assign q.outFormat = q.outValid ? fmt : 3'd0;
  assign q.outImm = imm;
  assign q.outIllegal = q.outValid && fmt == 3'd7;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: queue-based reference model compared every cycle, plus hand-computed decode points.
module tb_fetch_decode_queue;
  localparam int DEPTH = 4;
  localparam int XLEN = 32;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  fetch_decode_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus();
  fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clock(clock), .reset(reset), .q(bus));
  typedef struct packed {
    logic [2:0] fmt;
    logic [31:0] imm;
    logic ill;
  } dec_t;
  int checks = 0;
  int passes = 0;
  logic [63:0] mq[$];
  logic [63:0] hd;
  dec_t dd;
  bit hv;
  bit pu;
  bit po;
  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
  function automatic dec_t decode(logic [31:0] w);
    int s;
    dec_t d;
    s = $signed(w);
    d.fmt = 3'd7;
    d.imm = 32'd0;
    d.ill = 1'b0;
    case (w[6:0])
      7'h33: d.fmt = 3'd0;
      7'h13, 7'h03, 7'h67: begin
        d.fmt = 3'd1;
        d.imm = s >>> 20;
      end
      7'h23: begin
        d.fmt = 3'd2;
        d.imm = ((s >>> 25) << 5) | int'(w[11:7]);
      end
      7'h63: begin
        d.fmt = 3'd3;
        d.imm = ((s >>> 31) << 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
      end
      7'h37, 7'h17: begin
        d.fmt = 3'd4;
        d.imm = w & 32'hFFFFF000;
      end
      7'h6F: begin
        d.fmt = 3'd5;
        d.imm = ((s >>> 31) << 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask
  task automatic tick(logic iv, logic [31:0] ins, logic [31:0] pc, logic ordy, logic fl);
    bus.inValid = iv;
    bus.inInstr = ins;
    bus.inPC = pc;
    bus.outReady = ordy;
    bus.flush = fl;
    @(negedge clock);
  endtask
  always @(posedge clock or posedge reset) begin
    if (reset || bus.flush) mq.delete();
    else begin
      pu = bus.inValid && mq.size() < DEPTH;
      po = bus.outReady && mq.size() > 0;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back({bus.inPC, bus.inInstr});
    end
  end
  always @(negedge clock) begin
    if (!reset) begin
      hv = mq.size() > 0;
      hd = hv ? mq[0] : 64'd0;
      dd = hv ? decode(hd[31:0]) : '0;
      chk("count", bus.count, mq.size());
      chk("inReady", bus.inReady, mq.size() < DEPTH);
      chk("outValid", bus.outValid, hv);
      chk("outPC", bus.outPC, hd[63:32]);
      chk("outOpcode", bus.outOpcode, hd[6:0]);
      chk("outRd", bus.outRd, hd[11:7]);
      chk("outRs1", bus.outRs1, hd[19:15]);
      chk("outRs2", bus.outRs2, hd[24:20]);
      chk("outFunct3", bus.outFunct3, hd[14:12]);
      chk("outFunct7", bus.outFunct7, hd[31:25]);
      chk("outFormat", bus.outFormat, dd.fmt);
      chk("outImm", bus.outImm, dd.imm);
      chk("outIllegal", bus.outIllegal, dd.ill);
    end
  end
  initial begin
    logic [31:0] pc;
    bus.inValid = 1'b0;
    bus.inInstr = '0;
    bus.inPC = '0;
    bus.outReady = 1'b0;
    bus.flush = 1'b0;
    chk("model I imm", decode(32'h00A00093).imm, 32'd10);
    chk("model S imm", decode(32'h0020A423).imm, 32'd8);
    chk("model B imm", decode(32'hFE000EE3).imm, 32'hFFFFFFFC);
    chk("model J imm", decode(32'h008000EF).imm, 32'd8);
    chk("model U imm", decode(32'h123452B7).imm, 32'h12345000);
    chk("model illegal", decode(32'hFFFFFFFF), {3'd7, 32'd0, 1'b1});
    #12 reset = 1'b0;
    chk("rst inReady", bus.inReady, 1);
    chk("rst outValid", bus.outValid, 0);
    chk("rst count", bus.count, 0);
    chk("rst outFormat", bus.outFormat, 0);
    tick(1, 32'h00A00093, 32'h0, 0, 0);
    chk("I outValid", bus.outValid, 1);
    chk("I fmt", bus.outFormat, 1);
    chk("I rd", bus.outRd, 1);
    chk("I rs1", bus.outRs1, 0);
    chk("I funct3", bus.outFunct3, 0);
    chk("I imm", bus.outImm, 10);
    chk("I pc", bus.outPC, 0);
    tick(0, 0, 0, 1, 0);
    tick(1, 32'h0020A423, 32'h100, 0, 0);
    tick(1, 32'hFE000EE3, 32'h104, 0, 0);
    tick(1, 32'h008000EF, 32'h108, 0, 0);
    tick(1, 32'h123452B7, 32'h10C, 0, 0);
    chk("S fmt", bus.outFormat, 2);
    chk("S rs1", bus.outRs1, 1);
    chk("S rs2", bus.outRs2, 2);
    chk("S imm", bus.outImm, 8);
    tick(0, 0, 0, 1, 0);
    chk("B fmt", bus.outFormat, 3);
    chk("B imm", bus.outImm, 32'hFFFFFFFC);
    tick(0, 0, 0, 1, 0);
    chk("J fmt", bus.outFormat, 5);
    chk("J rd", bus.outRd, 1);
    chk("J imm", bus.outImm, 8);
    tick(0, 0, 0, 1, 0);
    chk("U fmt", bus.outFormat, 4);
    chk("U rd", bus.outRd, 5);
    chk("U imm", bus.outImm, 32'h12345000);
    chk("U pc", bus.outPC, 32'h10C);
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) tick(1, 32'h00000013 | (i << 7), i * 4, 0, 0);
    chk("full count", bus.count, 4);
    chk("full inReady", bus.inReady, 0);
    chk("full head pc", bus.outPC, 0);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        chk("wrap head pc", bus.outPC, k * 2);
        tick(0, 0, 0, 1, 0);
      end else tick(1, 32'h00000033, 32'h14 + (k / 2) * 4, 0, 0);
    end
    chk("wrap count", bus.count, 4);
    chk("wrap head pc", bus.outPC, 32'h14);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    chk("pre-sim count", bus.count, 2);
    tick(1, 32'h00000033, 32'h24, 1, 0);
    chk("sim count", bus.count, 2);
    chk("sim head pc", bus.outPC, 32'h20);
    tick(1, 32'h00000033, 32'h28, 0, 0);
    chk("pre-flush count", bus.count, 3);
    tick(1, 32'h00000033, 32'h2C, 1, 1);
    chk("flush count", bus.count, 0);
    chk("flush outValid", bus.outValid, 0);
    chk("flush fmt", bus.outFormat, 0);
    chk("flush opcode", bus.outOpcode, 0);
    chk("flush imm", bus.outImm, 0);
    chk("flush pc", bus.outPC, 0);
    tick(0, 0, 0, 0, 0);
    chk("flush lost word", bus.count, 0);
    tick(1, 32'hFFFFFFFF, 32'h30, 0, 0);
    chk("illegal fmt", bus.outFormat, 7);
    chk("illegal flag", bus.outIllegal, 1);
    chk("illegal imm", bus.outImm, 0);
    tick(1, 32'h00A00093, 32'h34, 0, 0);
    chk("pre-reset count", bus.count, 2);
    bus.inValid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async rst count", bus.count, 0);
    chk("async rst outValid", bus.outValid, 0);
    chk("async rst inReady", bus.inReady, 1);
    chk("async rst illegal", bus.outIllegal, 0);
    chk("async rst fmt", bus.outFormat, 0);
    chk("async rst pc", bus.outPC, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    pc = 32'h1000;
    for (int n = 0; n < 400; n++) begin
      tick($urandom_range(0, 3) != 0,
           ($urandom() & 32'hFFFFFF80) | 32'(ops[$urandom_range(0, 9)]),
           pc,
           n < 200 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0);
      pc += 4;
    end
    tick(0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Receiving end of the Fetch stage output: buffers fetched instruction words with their PCs and hands them to the execute side already field-decoded.
- Per-entry valid/ready handshakes on both sides.
- Flush input discards all queued instructions on a jump/branch redirect (JAL/JALR/branch target taken by Fetch).
- Sits between Fetch and the register-file/ALU control logic.

Parameters:
- DEPTH, 4, number of queued entries; power of two, at least 2.
- XLEN, 32, instruction and PC width.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clears the queue.
- inValid  input  1  Fetch presents a word this cycle.
- inInstr  input  XLEN  instruction word from Fetch (outINPUT side).
- inPC  input  XLEN  PC of inInstr.
- inReady  output  1  queue can accept; equals !full.
- flush  input  1  redirect; empties the queue at the next edge.
- outReady  input  1  consumer takes the head entry.
- outValid  output  1  head entry present; equals !empty.
- outPC  output  XLEN  PC of the head entry.
- outOpcode  output  7  head instr[6:0].
- outRd  output  5  instr[11:7].
- outRs1  output  5  instr[19:15].
- outRs2  output  5  instr[24:20].
- outFunct3  output  3  instr[14:12].
- outFunct7  output  7  instr[31:25].
- outFormat  output  3  R=0, I=1, S=2, B=3, U=4, J=5, unknown=7.
- outImm  output  XLEN  sign-extended immediate.
- outIllegal  output  1  opcode not recognised.
- count  output  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Storage: circular buffer of {PC, instr}, with a write pointer, a read pointer and a registered count. Pointers wrap modulo DEPTH.
- Reset (asynchronous, any cycle, including mid-transfer): pointers and count go to 0. Result: inReady=1, outValid=0, count=0, and every decoded output is 0.
- Push occurs when inValid && inReady. inReady is computed from the registered count only: there is no same-cycle bypass, so a full queue refuses a word even while a pop happens in the same cycle.
- Pop occurs when outValid && outReady.
- Push and pop in the same cycle (not full, not empty): count is unchanged and both pointers advance.
- Empty-queue push: the entry becomes visible on the outputs the cycle after the edge. Latency is 1 cycle; there is no fall-through.
- Full: inReady=0 and inValid is ignored. Empty: outValid=0 and outReady is ignored.
- Flush has priority over push and pop. At the next edge, pointers and count go to 0. A push or pop presented in the flush cycle has no effect.
- Decode is combinational from the head entry. When outValid=0, all decoded outputs and outPC are forced to 0.
- Opcode to format mapping:
  - 0110011 → R
  - 0010011, 0000011, 1100111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - any other → format 7, outIllegal=1, outImm=0
- Immediates, all sign-extended from instr[31]:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'b0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R = 0
- An illegal entry is still queued and popped normally. Flagging it is the consumer's job.
- count never exceeds DEPTH and never underflows.

Test Plan:
- Reset and decode: hold reset 10 ns, then verify inReady=1, outValid=0, count=0. Push 0x00A00093 at PC 0x0. Next cycle: outValid=1, format=1, outRd=1, outRs1=0, outFunct3=0, outImm=10, outPC=0.
- Immediate formats, pushed back-to-back and popped in order:
  - 0x0020A423 → S, outRs1=1, outRs2=2, outImm=8.
  - 0xFE000EE3 → B, outImm=0xFFFFFFFC.
  - 0x008000EF → J, outRd=1, outImm=8.
  - 0x123452B7 → U, outRd=5, outImm=0x12345000.
- Full and wrap-around: with outReady=0, push 5 words with PCs 0x0,0x4,…,0x10. Only 4 are accepted, count=4, inReady=0. Then pop and push alternately for 8 cycles; PCs come out strictly in order across the pointer wrap.
- Simultaneous push and pop at count=2: count stays 2 and the head advances to the next PC.
- Flush: with count=3, assert flush together with inValid=1 and outReady=1. Next cycle: count=0, outValid=0, all decoded outputs 0, and the pushed word is lost.
- Illegal opcode and mid-operation reset: push 0xFFFFFFFF → format 7, outIllegal=1, outImm=0. Then assert reset asynchronously between clock edges with count=2: outputs clear immediately, without waiting for a clock edge.
